// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port between NUM_REQ packet writers; B responses are routed back by ID.
// Optional DDR_REGION_EN: the top address bits carry the grant index so each requester gets a private DDR partition.
module ddr_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]                    s_awaddr,
  input  logic [NUM_REQ*8-1:0]                             s_awlen,
  input  logic [NUM_REQ-1:0]                               s_awvalid,
  output logic [NUM_REQ-1:0]                               s_awready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                    s_wdata,
  input  logic [NUM_REQ-1:0]                               s_wlast,
  input  logic [NUM_REQ-1:0]                               s_wvalid,
  output logic [NUM_REQ-1:0]                               s_wready,
  output logic [NUM_REQ-1:0]                               s_bvalid,
  input  logic [NUM_REQ-1:0]                               s_bready,
  output logic [ID_WIDTH-1:0]                              m_awid,
  output logic [ADDR_WIDTH-1:0]                            m_awaddr,
  output logic [7:0]                                       m_awlen,
  output logic [2:0]                                       m_awsize,
  output logic [1:0]                                       m_awburst,
  output logic                                             m_awvalid,
  input  logic                                             m_awready,
  output logic [DATA_WIDTH-1:0]                            m_wdata,
  output logic [DATA_WIDTH/8-1:0]                          m_wstrb,
  output logic                                             m_wlast,
  output logic                                             m_wvalid,
  input  logic                                             m_wready,
  input  logic [ID_WIDTH-1:0]                              m_bid,
  input  logic                                             m_bvalid,
  output logic                                             m_bready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx,
  output logic                                             len_err,
  output logic [31:0]                                      burst_cnt
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state, state_nx;
  logic [GW-1:0]           rr_ptr;
  logic [GW-1:0]           scan_idx;
  logic                    scan_hit;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [7:0]              sel_len;
  logic                    sel_awvalid;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_wlast;
  logic                    sel_wvalid;
  logic                    aw_hs;
  logic                    w_hs;
  logic [GW-1:0]           rr_next;

  // Slice mux for the granted requester.
  always_comb begin
    sel_addr    = '0;
    sel_len     = '0;
    sel_awvalid = 1'b0;
    sel_wdata   = '0;
    sel_wlast   = 1'b0;
    sel_wvalid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == GW'(i)) begin
        sel_addr    = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len     = s_awlen[i*8 +: 8];
        sel_awvalid = s_awvalid[i];
        sel_wdata   = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wlast   = s_wlast[i];
        sel_wvalid  = s_wvalid[i];
      end
    end
  end

  // Pick the requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    int best;
    int d;
    scan_hit = 1'b0;
    scan_idx = '0;
    best     = NUM_REQ;
    d        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_awvalid[i]) begin
        d = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_REQ - int'(rr_ptr));
        if (d < best) begin
          best     = d;
          scan_hit = 1'b1;
          scan_idx = GW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_awready = '0;
    s_wready  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    case (state)
      IDLE: begin
        if (scan_hit) state_nx = ADDR;
      end
      ADDR: begin
        m_awvalid = sel_awvalid;
        for (int i = 0; i < NUM_REQ; i++)
          s_awready[i] = m_awready && (grant_idx == GW'(i));
        if (sel_awvalid && m_awready) state_nx = DATA;
      end
      DATA: begin
        m_wvalid = sel_wvalid;
        m_wlast  = sel_wlast;
        for (int i = 0; i < NUM_REQ; i++)
          s_wready[i] = m_wready && (grant_idx == GW'(i));
        if (sel_wvalid && m_wready && sel_wlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign aw_hs   = (state == ADDR) && m_awvalid && m_awready;
  assign w_hs    = (state == DATA) && m_wvalid && m_wready;
  assign rr_next = (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + GW'(1);

  // beat_cnt holds the pre-increment index of the current beat, so a well-formed last beat sees beat_cnt == len_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (state == IDLE && scan_hit) grant_idx <= scan_idx;
      if (aw_hs) begin
        len_q    <= sel_len;
        beat_cnt <= '0;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (m_wlast) begin
          rr_ptr    <= rr_next;
          burst_cnt <= burst_cnt + 32'd1;
          if (beat_cnt != len_q) len_err <= 1'b1;
        end else if (beat_cnt == len_q) begin
          len_err <= 1'b1;
        end
      end
    end
  end

  assign m_awid    = ID_WIDTH'(grant_idx);
  assign m_awlen   = sel_len;
  assign m_awsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_awburst = 2'b01;
  assign m_wdata   = sel_wdata;
  assign m_wstrb   = '1;

`ifdef DDR_REGION_EN
  assign m_awaddr = {grant_idx, sel_addr[ADDR_WIDTH-GW-1:0]};
`else
  assign m_awaddr = sel_addr;
`endif

  // B routing ignores the FSM; IDs outside the requester range are drained and dropped.
  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_bid == ID_WIDTH'(i)) begin
        s_bvalid[i] = m_bvalid;
        m_bready    = s_bready[i];
      end
    end
  end

endmodule

// File: doc/ddr_wr_arbiter.md
Name: ddr_wr_arbiter

Overview:
Round-robin arbiter sharing one AXI4 write port to DDR between NUM_REQ ingress packet writers (one per MRMAC port).
- Grants the write port per burst and holds the grant from the AW handshake through the WLAST beat.
- Tags each AW with the requester index so B responses route back to the originating requester.
- Sits between the ingress controllers and the DDR memory controller / NoC.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 31, AXI address width
DATA_WIDTH, 512, AXI data width
ID_WIDTH, 4, AXI ID width; must be >= clog2(NUM_REQ)

Ports:
clk  in  1  clock
rst  in  1  reset
s_awaddr  in  NUM_REQ*ADDR_WIDTH  per-requester AW address, requester i at slice i
s_awlen  in  NUM_REQ*8  per-requester burst length
s_awvalid  in  NUM_REQ  AW valid
s_awready  out  NUM_REQ  AW ready
s_wdata  in  NUM_REQ*DATA_WIDTH  W data
s_wlast  in  NUM_REQ  W last
s_wvalid  in  NUM_REQ  W valid
s_wready  out  NUM_REQ  W ready
s_bvalid  out  NUM_REQ  routed B valid
s_bready  in  NUM_REQ  B ready
m_awid  out  ID_WIDTH  grant index, zero-extended
m_awaddr  out  ADDR_WIDTH  granted address
m_awlen  out  8  granted burst length
m_awsize  out  3  constant clog2(DATA_WIDTH/8)
m_awburst  out  2  constant 2'b01 (INCR)
m_awvalid  out  1  AW valid
m_awready  in  1  AW ready
m_wdata  out  DATA_WIDTH  W data
m_wstrb  out  DATA_WIDTH/8  all ones
m_wlast  out  1  W last
m_wvalid  out  1  W valid
m_wready  in  1  W ready
m_bid  in  ID_WIDTH  B ID
m_bvalid  in  1  B valid
m_bready  out  1  B ready
grant_idx  out  clog2(NUM_REQ), min 1  current or last grant
len_err  out  1  sticky burst-length mismatch flag
burst_cnt  out  32  completed bursts, wraps

Behaviour:
- Reset: rst synchronous, active-high, on clk.
  - Outputs 0: all s_awready, s_wready, m_awvalid, m_wvalid, grant_idx, len_err, burst_cnt.
  - State IDLE, round-robin pointer rr_ptr = 0.
  - Reset mid-burst abandons the burst; no completion of the partial burst.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Scan s_awvalid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is registered into grant_idx; go to ADDR next cycle.
  - No request: stay in IDLE.
- ADDR:
  - m_awvalid = s_awvalid[g]; m_awaddr and m_awlen come from slice g (combinational pass-through).
  - s_awready[g] = m_awready; all other s_awready = 0.
  - On the m_awvalid && m_awready handshake: latch awlen into len_q, clear beat_cnt, go to DATA.
- DATA:
  - m_wdata, m_wlast and m_wvalid come from slice g; s_wready[g] = m_wready; other s_wready = 0.
  - Each accepted beat increments 8-bit beat_cnt.
  - On an accepted beat with wlast:
    - Go to IDLE.
    - rr_ptr <= (g+1) mod NUM_REQ.
    - burst_cnt++.
    - If beat_cnt != len_q, set len_err.
  - An accepted beat with beat_cnt == len_q and wlast=0 also sets len_err. The burst still ends only on wlast.
- W beats are never forwarded before the AW handshake of the same burst. A requester presenting AW and first W together is stalled on W until DATA.
- Minimum arbitration overhead is 1 idle cycle per burst (the IDLE->ADDR cycle).
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- B path:
  - s_bvalid[i] = m_bvalid && (m_bid == i); m_bready = s_bready[m_bid].
  - m_bid >= NUM_REQ: m_bready = 1 and the response is discarded.
  - The B path is independent of the FSM; B may arrive during any state.
- Simultaneous requests in IDLE: rr_ptr-first priority decides.
- s_awvalid deasserted during ADDR: m_awvalid follows it to 0 and the FSM stays in ADDR. A granted requester must not withdraw; no timeout.

Optional Feature:
DDR_REGION_EN
- Defined: m_awaddr top clog2(NUM_REQ) bits are replaced by grant_idx, giving each requester a private DDR partition of 2^(ADDR_WIDTH-clog2(NUM_REQ)) bytes. Lower bits pass through.
- Undefined: m_awaddr is exactly s_awaddr[g].

Test Plan:
- Single requester 0: awaddr=0x100, awlen=1, 2 beats, m_ready tied 1 -> one AW with awid=0, 2 W beats with wlast on beat 2, burst_cnt=1, len_err=0.
- Requesters 0 and 1 raise AW in the same cycle with rr_ptr=0 -> req0 burst completes first, then req1; s_wready[1]=0 throughout req0's burst.
- Three back-to-back bursts per requester, NUM_REQ=2 -> grant order 0,1,0,1,0,1; burst_cnt=6.
- m_wready toggled 1-0-1-0 during awlen=3 -> 4 beats, data in order, no beat duplicated or lost.
- awlen=2 but wlast on 2nd beat -> len_err=1 and stays set; FSM returns to IDLE; next burst proceeds normally.
- m_bid=1 with m_bvalid=1 and s_bready[1]=0 -> s_bvalid[1]=1, s_bvalid[0]=0, m_bready=0. With DDR_REGION_EN, NUM_REQ=2, req1 awaddr=0x40 -> m_awaddr=0x40000040.
